// File: rtl/frame_pixel_writer.sv
// Pixel sink for the board drawer: clips off-screen pixels, buffers the rest in a FIFO,
// writes them to the frame buffer when granted, and pulses frame_done once a frame is fully written.
module frame_pixel_writer #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [9:0]  in_x,
   input  logic [8:0]  in_y,
   input  logic [23:0] in_color,
   output logic        in_ready,
   input  logic        in_done,
   input  logic        fb_grant,
   output logic        fb_wren,
   output logic [18:0] fb_addr,
   output logic [23:0] fb_data,
   output logic        frame_done,
   output logic [7:0]  clip_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [18:0] addr;
      logic [23:0] color;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_DONE
   } state_t;

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_fb_wren;
   logic [18:0]   r_fb_addr;
   logic [23:0]   r_fb_data;
   logic [7:0]    r_clip_count;
   logic          r_done_prev;
   state_t        r_state;
   state_t        w_state_next;

   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic          w_clip;
   logic          w_push;
   logic          w_pop;
   logic          w_done_rise;
   logic [18:0]   w_addr;

   assign w_full      = (r_count == FULL_COUNT);
   assign w_empty     = (r_count == '0);
   assign w_accept    = in_valid && !w_full;
   assign w_clip      = (32'(in_x) >= SCREEN_W) || (32'(in_y) >= SCREEN_H);
   assign w_push      = w_accept && !w_clip;
   assign w_pop       = !w_empty && fb_grant;
   assign w_done_rise = in_done && !r_done_prev;
   // Constant stride, so this reduces to shifts and adds ((y<<9)+(y<<7)+x for 640).
   assign w_addr      = 19'(32'(in_y) * SCREEN_W + 32'(in_x));

   // NOTE: the storage array has no reset; only pointers and count are cleared, so stale
   // entries are unreachable and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{addr: w_addr, color: in_color};
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_fb_wren    <= 1'b0;
         r_fb_addr    <= '0;
         r_fb_data    <= '0;
         r_clip_count <= '0;
         r_done_prev  <= 1'b1;
      end else begin
         r_done_prev <= in_done;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_fb_addr <= r_mem[r_rd_ptr].addr;
            r_fb_data <= r_mem[r_rd_ptr].color;
         end
         r_fb_wren <= w_pop;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_accept && w_clip && (r_clip_count != 8'hFF)) begin
            r_clip_count <= r_clip_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_done_rise) w_state_next = S_DRAIN;
         // Wait until the last write has also left the output register.
         S_DRAIN: if (w_empty && !r_fb_wren) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      frame_done = (r_state == S_DONE);
   end

   assign in_ready   = !w_full;
   assign fb_wren    = r_fb_wren;
   assign fb_addr    = r_fb_addr;
   assign fb_data    = r_fb_data;
   assign clip_count = r_clip_count;

endmodule
